// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS 32-bit control registers with
// byte-strobed writes, readback, per-register write pulses and SLVERR for
// indices beyond the implemented range. All outputs come straight from flops.
module axi_lite_regbank #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_REGS   = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]   REG_OUT,
    output logic [NUM_REGS-1:0]      REG_WR_STB
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {WR_COLLECT = 2'd0, WR_COMMIT = 2'd1, WR_RESP = 2'd2} wr_state_t;
    typedef enum logic {RD_IDLE = 1'b0, RD_RESP = 1'b1} rd_state_t;

    // Merge write data into the old word byte by byte under the strobe mask.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    wr_state_t               wr_state_r, wr_state_s;
    rd_state_t               rd_state_r, rd_state_s;
    logic                    aw_held_r, aw_held_s, w_held_r, w_held_s;
    logic                    awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic [1:0]              bresp_r, rresp_r;
    logic [IDX_W-1:0]        wr_idx_r;
    logic [31:0]             wdata_r, rdata_r, rd_data_s;
    logic [3:0]              wstrb_r;
    logic [31:0]             regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]     wr_stb_r, wr_sel_s;
    logic                    wr_hit_s, rd_hit_s;
    logic                    aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic                    unused_s;

    assign aw_hs_s = S_AXI_AWVALID & awready_r;
    assign w_hs_s  = S_AXI_WVALID  & wready_r;
    assign b_hs_s  = S_AXI_BREADY  & bvalid_r;
    assign ar_hs_s = S_AXI_ARVALID & arready_r;
    assign r_hs_s  = S_AXI_RREADY  & rvalid_r;

    // Protection bits and byte offsets carry no meaning for this bank.
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign REG_WR_STB    = wr_stb_r;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign REG_OUT[32*g +: 32] = regs_r[g];
    end

    // One-hot select of the held write index; no bit set means out of range.
    always_comb begin
        wr_sel_s = {NUM_REGS{1'b0}};
        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_idx_r == IDX_W'(k)) begin
                wr_sel_s[k] = 1'b1;
            end else begin
                wr_sel_s[k] = 1'b0;
            end
        end
        wr_hit_s = |wr_sel_s;
    end

    // Read mux from the live AR address; unmatched indices read as zero.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        rd_hit_s  = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (S_AXI_ARADDR[ADDR_WIDTH-1:2] == IDX_W'(k)) begin
                rd_data_s = regs_r[k];
                rd_hit_s  = 1'b1;
            end else begin
                rd_data_s = rd_data_s;
                rd_hit_s  = rd_hit_s;
            end
        end
    end

    // Write FSM next state: collect AW and W independently, commit once, respond.
    always_comb begin
        wr_state_s = wr_state_r;
        aw_held_s  = aw_held_r;
        w_held_s   = w_held_r;
        case (wr_state_r)
            WR_COLLECT: begin
                if (aw_hs_s) begin
                    aw_held_s = 1'b1;
                end else begin
                    aw_held_s = aw_held_r;
                end
                if (w_hs_s) begin
                    w_held_s = 1'b1;
                end else begin
                    w_held_s = w_held_r;
                end
                if (aw_held_s && w_held_s) begin
                    wr_state_s = WR_COMMIT;
                end else begin
                    wr_state_s = WR_COLLECT;
                end
            end
            WR_COMMIT: begin
                wr_state_s = WR_RESP;
            end
            WR_RESP: begin
                if (b_hs_s) begin
                    wr_state_s = WR_COLLECT;
                    aw_held_s  = 1'b0;
                    w_held_s   = 1'b0;
                end else begin
                    wr_state_s = WR_RESP;
                end
            end
            default: begin
                wr_state_s = WR_COLLECT;
                aw_held_s  = 1'b0;
                w_held_s   = 1'b0;
            end
        endcase
    end

    // Write FSM state, readies, captured AW/W payload and the B response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_r <= WR_COLLECT;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
            bvalid_r   <= 1'b0;
            bresp_r    <= 2'b00;
            wr_idx_r   <= {IDX_W{1'b0}};
            wdata_r    <= 32'h0000_0000;
            wstrb_r    <= 4'h0;
        end else begin
            wr_state_r <= wr_state_s;
            aw_held_r  <= aw_held_s;
            w_held_r   <= w_held_s;
            awready_r  <= (wr_state_s == WR_COLLECT) && !aw_held_s;
            wready_r   <= (wr_state_s == WR_COLLECT) && !w_held_s;
            if (aw_hs_s) begin
                wr_idx_r <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs_s) begin
                wdata_r <= S_AXI_WDATA;
                wstrb_r <= S_AXI_WSTRB;
            end
            if (wr_state_r == WR_COMMIT) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_hit_s ? 2'b00 : 2'b10;
            end else if (b_hs_s) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Register file update and write pulse, both landing on the commit edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_r[k] <= 32'h0000_0000;
            end
            wr_stb_r <= {NUM_REGS{1'b0}};
        end else if (wr_state_r == WR_COMMIT) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_sel_s[k]) begin
                    regs_r[k] <= apply_strb(regs_r[k], wdata_r, wstrb_r);
                end
            end
            wr_stb_r <= wr_sel_s;
        end else begin
            wr_stb_r <= {NUM_REGS{1'b0}};
        end
    end

    // Read FSM next state.
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            RD_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_s = RD_RESP;
                end else begin
                    rd_state_s = RD_IDLE;
                end
            end
            RD_RESP: begin
                if (r_hs_s) begin
                    rd_state_s = RD_IDLE;
                end else begin
                    rd_state_s = RD_RESP;
                end
            end
            default: begin
                rd_state_s = RD_IDLE;
            end
        endcase
    end

    // Read FSM state and R channel; data is sampled from pre-edge register values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_r <= RD_IDLE;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            rresp_r    <= 2'b00;
        end else begin
            rd_state_r <= rd_state_s;
            arready_r  <= (rd_state_s == RD_IDLE);
            if (ar_hs_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_data_s;
                rresp_r  <= rd_hit_s ? 2'b00 : 2'b10;
            end else if (r_hs_s) begin
                rvalid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: directed scenarios plus a
// randomized write/read mix checked against an array model of the registers.
module tb_axi_lite_regbank;

    logic         aclk = 1'b0;
    logic         areset;
    logic [11:0]  awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [511:0] reg_out;
    logic [15:0]  reg_wr_stb;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [16];

    axi_lite_regbank #(.ADDR_WIDTH(12), .NUM_REGS(16)) dut (
        .ACLK(aclk), .ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .REG_OUT(reg_out), .REG_WR_STB(reg_wr_stb)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [511:0] model_vec();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = model[k];
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Full write: W is presented w_lead cycles before AW; collects strobes seen.
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, output logic [1:0] resp, output logic [15:0] stb_acc,
                             output bit to);
        bit aw_done, b_done, aw_hs, w_hs, b_hs;
        int cyc;
        aw_done = 0; b_done = 0; cyc = 0; resp = 2'b11; stb_acc = 16'h0;
        awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
        wvalid = 1'b1; awvalid = (w_lead == 0);
        while (!b_done && cyc < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            if (b_hs) resp = bresp;
            tick();
            cyc++;
            stb_acc |= reg_wr_stb;
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs) wvalid = 1'b0;
            if (b_hs) b_done = 1;
            if (!aw_done && cyc >= w_lead) awvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        to = !b_done;
    endtask

    // Full read with RREADY held low for 'hold' cycles after RVALID rises.
    task automatic axi_read(input logic [11:0] addr, input int hold, output logic [31:0] data,
                            output logic [1:0] resp, output bit to);
        bit r_done, ar_hs, r_hs;
        int cyc, waited;
        r_done = 0; cyc = 0; waited = 0; data = 32'hX; resp = 2'b11;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        while (!r_done && cyc < 60) begin
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (r_hs) begin data = rdata; resp = rresp; end
            tick();
            cyc++;
            if (ar_hs) arvalid = 1'b0;
            if (r_hs) begin r_done = 1; rready = 1'b0; end
            else if (rvalid && !rready) begin
                if (waited >= hold) rready = 1'b1;
                else waited++;
            end
        end
        arvalid = 1'b0; rready = 1'b0;
        to = !r_done;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick(); tick();
        checks++; if (reg_out !== 512'h0) begin errors++; $display("FAIL reset_reg_out: got %h want 0", reg_out); end
        checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL reset_readies: got %b want 111", {awready, wready, arready}); end
        checks++; if ({bvalid, rvalid, bresp, rresp, reg_wr_stb} !== 22'h0) begin errors++; $display("FAIL reset_valids: got %h want 0", {bvalid, rvalid, bresp, rresp, reg_wr_stb}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        areset = 1'b0;
        for (int k = 0; k < 16; k++) model[k] = 32'h0;
    endtask

    task automatic test_same_cycle_write();
        awaddr = 12'h008; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++; if ({awready, wready, bvalid} !== 3'b000) begin errors++; $display("FAIL sc_after_hs: got %b want 000", {awready, wready, bvalid}); end
        tick();
        model[2] = 32'hDEADBEEF;
        checks++; if (reg_out[64 +: 32] !== 32'hDEADBEEF) begin errors++; $display("FAIL sc_reg2: got %h want deadbeef", reg_out[64 +: 32]); end
        checks++; if (reg_wr_stb !== 16'h0004) begin errors++; $display("FAIL sc_stb: got %h want 0004", reg_wr_stb); end
        checks++; if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL sc_bresp: got %b want 100", {bvalid, bresp}); end
        tick();
        checks++; if ({bvalid, reg_wr_stb} !== 17'h0) begin errors++; $display("FAIL sc_b_done: got %h want 0", {bvalid, reg_wr_stb}); end
        checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL sc_ready_back: got %b want 11", {awready, wready}); end
    endtask

    task automatic test_w_before_aw();
        int nb;
        wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1; bready = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({wready, awready} !== 2'b01) begin errors++; $display("FAIL wa_wait%0d: got %b want 01", i, {wready, awready}); end
            tick();
        end
        awaddr = 12'h008; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        model[2] = merge(model[2], 32'h000000AA, 4'h1);
        checks++; if (reg_out[64 +: 32] !== model[2]) begin errors++; $display("FAIL wa_reg2: got %h want %h", reg_out[64 +: 32], model[2]); end
        checks++; if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL wa_bresp: got %b want 100", {bvalid, bresp}); end
        nb = 0;
        for (int i = 0; i < 4; i++) begin tick(); nb += int'(bvalid); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL wa_single_b: got %0d extra want 0", nb); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [15:0] stb; logic [31:0] d; bit to;
        axi_write(12'h040, 32'hCAFEF00D, 4'hF, 0, resp, stb, to);
        checks++; if (to || resp !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %b (to=%0d) want 10", resp, to); end
        checks++; if (stb !== 16'h0) begin errors++; $display("FAIL oor_stb: got %h want 0", stb); end
        checks++; if (reg_out !== model_vec()) begin errors++; $display("FAIL oor_reg_out: got %h want %h", reg_out, model_vec()); end
        axi_read(12'h044, 0, d, resp, to);
        checks++; if (to || resp !== 2'b10 || d !== 32'h0) begin errors++; $display("FAIL oor_read: got %b/%h want 10/0", resp, d); end
    endtask

    task automatic test_read_backpressure();
        araddr = 12'h008; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rvalid, arready, rresp} !== 4'b1000 || rdata !== model[2]) begin
                errors++; $display("FAIL bp_hold%0d: got v/ar/resp %b data %h want 1000 %h", i, {rvalid, arready, rresp}, rdata, model[2]);
            end
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        checks++; if ({rvalid, arready} !== 2'b01) begin errors++; $display("FAIL bp_release: got %b want 01", {rvalid, arready}); end
    endtask

    task automatic test_read_write_collision();
        logic [31:0] old_v, d; logic [1:0] resp; bit to;
        old_v = model[2];
        awaddr = 12'h008; wdata = 32'h12345678; wstrb = 4'hF; bready = 1'b1; rready = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 12'h008; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        model[2] = 32'h12345678;
        checks++; if ({rvalid, rresp} !== 3'b100 || rdata !== old_v) begin errors++; $display("FAIL col_old: got %h want %h", rdata, old_v); end
        tick(); tick();
        rready = 1'b0;
        axi_read(12'h008, 1, d, resp, to);
        checks++; if (to || resp !== 2'b00 || d !== 32'h12345678) begin errors++; $display("FAIL col_new: got %b/%h want 00/12345678", resp, d); end
    endtask

    task automatic test_random();
        logic [1:0] resp; logic [15:0] stb, exp_stb; logic [31:0] d, dat, exp_d;
        logic [3:0] s; logic [11:0] a; bit to; int idx;
        for (int it = 0; it < 40; it++) begin
            idx = $urandom_range(0, 17);
            a = 12'(idx * 4 + $urandom_range(0, 3));
            dat = $urandom; s = 4'($urandom_range(0, 15));
            axi_write(a, dat, s, $urandom_range(0, 3), resp, stb, to);
            exp_stb = 16'h0;
            if (idx < 16) begin model[idx] = merge(model[idx], dat, s); exp_stb[idx] = 1'b1; end
            checks++;
            if (to || resp !== ((idx < 16) ? 2'b00 : 2'b10) || stb !== exp_stb) begin
                errors++; $display("FAIL rnd_wr%0d: got resp %b stb %h to %0d want idx %0d stb %h", it, resp, stb, to, idx, exp_stb);
            end
            checks++; if (reg_out !== model_vec()) begin errors++; $display("FAIL rnd_regs%0d: got %h want %h", it, reg_out, model_vec()); end
            idx = $urandom_range(0, 17);
            a = 12'(idx * 4 + $urandom_range(0, 3));
            axi_read(a, $urandom_range(0, 3), d, resp, to);
            exp_d = (idx < 16) ? model[idx] : 32'h0;
            checks++;
            if (to || resp !== ((idx < 16) ? 2'b00 : 2'b10) || d !== exp_d) begin
                errors++; $display("FAIL rnd_rd%0d: got %b/%h want idx %0d data %h", it, resp, d, idx, exp_d);
            end
        end
    endtask

    task automatic test_reset_during_bresp();
        awaddr = 12'h00C; wdata = $urandom | 32'h1; wstrb = 4'hF; bready = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick(); tick();
        checks++; if (bvalid !== 1'b1 || reg_out[96 +: 32] !== wdata) begin errors++; $display("FAIL rb_pending: got %b %h want 1 %h", bvalid, reg_out[96 +: 32], wdata); end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        for (int k = 0; k < 16; k++) model[k] = 32'h0;
        checks++; if ({bvalid, rvalid, reg_wr_stb} !== 18'h0) begin errors++; $display("FAIL rb_valids: got %h want 0", {bvalid, rvalid, reg_wr_stb}); end
        checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL rb_readies: got %b want 111", {awready, wready, arready}); end
        checks++; if (reg_out !== 512'h0) begin errors++; $display("FAIL rb_reg_out: got %h want 0", reg_out); end
    endtask

    initial begin
        areset = 1'b1; awaddr = 12'h0; araddr = 12'h0; awprot = 3'b000; arprot = 3'b000;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = 32'h0; wstrb = 4'h0;
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_out_of_range();
        test_read_backpressure();
        test_read_write_collision();
        test_random();
        test_reset_during_bresp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
